// File: rtl/pipe_mem_stage.sv
// MEM stage of the pipeline: EX/M register plus a small IDLE/BUSY/ERR handshake FSM
// towards the data memory, with alignment check and ack timeout.
//
// state | meaning
// IDLE  | M holds a non-memory op, a bubble, or nothing since reset
// BUSY  | memory access in flight, waiting for dmem_ack
// ERR   | one-cycle slot for a misaligned or timed-out access
module pipe_mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic [31:0] ealu,
    input  logic [31:0] eb,
    input  logic [4:0]  ern,
    output logic        mwreg,
    output logic        mm2reg,
    output logic [4:0]  mrn,
    output logic [31:0] malu,
    output logic [31:0] mmo,
    output logic        mvalid,
    output logic        mem_stall,
    output logic        mem_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    state_t      state;
    logic        wreg_q;
    logic        mwmem;
    logic        mfull;
    logic [31:0] mb;
    logic [7:0]  busy_cnt;

    logic        load_en;
    logic        e_memop;
    logic        e_misal;
    logic        timeout_hit;

    assign mem_stall   = (state == BUSY) && !dmem_ack;
    assign load_en     = !mem_stall;
    assign e_memop     = em2reg || ewmem;
    assign e_misal     = (ealu[1:0] != 2'b00);
    assign timeout_hit = mem_stall && (busy_cnt == TO_LIMIT);

    // The EX/M register is frozen during BUSY, so the bus fields are stable for the whole access.
    assign dmem_req   = (state == BUSY);
    assign dmem_addr  = malu;
    assign dmem_wdata = mb;
    assign dmem_we    = mwmem && (state == BUSY);
    assign mem_err    = (state == ERR);
    assign mwreg      = wreg_q && (state != ERR);
    assign mvalid     = ((state == IDLE) && mfull) || ((state == BUSY) && dmem_ack) || (state == ERR);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            wreg_q   <= 1'b0;
            mm2reg   <= 1'b0;
            mwmem    <= 1'b0;
            mrn      <= 5'd0;
            malu     <= 32'd0;
            mb       <= 32'd0;
            mfull    <= 1'b0;
            mmo      <= 32'd0;
            busy_cnt <= 8'd0;
        end else if (load_en) begin
            wreg_q <= ewreg;
            mm2reg <= em2reg;
            mwmem  <= ewmem;
            mrn    <= ern;
            malu   <= ealu;
            mb     <= eb;
            mfull  <= 1'b1;
            // load_en in BUSY implies this is the ack edge
            if (state == BUSY && mm2reg) begin
                mmo <= dmem_rdata;
            end
            if (e_memop && !e_misal) begin
                state    <= BUSY;
                busy_cnt <= 8'd0;
            end else if (e_memop) begin
                state <= ERR;
                mmo   <= 32'd0;
            end else begin
                state <= IDLE;
            end
        end else if (timeout_hit) begin
            state <= ERR;
            mmo   <= 32'd0;
        end else begin
            busy_cnt <= busy_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Bench for pipe_mem_stage: directed scenarios with literal expectations, then random
// instruction streams checked every cycle against a transaction-level model.
module tb_pipe_mem_stage;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic        ewreg, em2reg, ewmem;
    logic [31:0] ealu, eb;
    logic [4:0]  ern;
    logic        mwreg, mm2reg;
    logic [4:0]  mrn;
    logic [31:0] malu, mmo;
    logic        mvalid, mem_stall, mem_err;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    always #5 clock = ~clock;

    pipe_mem_stage #(.TIMEOUT(TO)) dut (
        .clock(clock), .resetn(resetn),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .ealu(ealu), .eb(eb), .ern(ern),
        .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .malu(malu), .mmo(mmo),
        .mvalid(mvalid), .mem_stall(mem_stall), .mem_err(mem_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the instruction sitting in M and which slot it occupies (0 plain, 1 memory access, 2 error).
    bit          pres;
    bit          i_wreg, i_m2reg, i_wmem;
    logic [4:0]  i_rn;
    logic [31:0] i_alu, i_b;
    int          phase;
    int          cyc_in_access;
    int          plan_k;
    logic [31:0] mmo_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pres = 0; i_wreg = 0; i_m2reg = 0; i_wmem = 0; i_rn = '0; i_alu = '0; i_b = '0;
        phase = 0; cyc_in_access = 0; plan_k = 0; mmo_e = '0;
    endtask

    task automatic compare();
        bit exp_valid;
        exp_valid = (phase == 0) ? pres : (phase == 1) ? dmem_ack : 1'b1;
        check("mwreg",     32'(mwreg),     32'((phase == 2) ? 1'b0 : i_wreg));
        check("mm2reg",    32'(mm2reg),    32'(i_m2reg));
        check("mrn",       32'(mrn),       32'(i_rn));
        check("malu",      malu,           i_alu);
        check("mmo",       mmo,            mmo_e);
        check("mvalid",    32'(mvalid),    32'(exp_valid));
        check("mem_stall", 32'(mem_stall), 32'((phase == 1) && !dmem_ack));
        check("mem_err",   32'(mem_err),   32'(phase == 2));
        check("dmem_req",  32'(dmem_req),  32'(phase == 1));
        if (phase == 1) begin
            check("dmem_addr",  dmem_addr,     i_alu);
            check("dmem_wdata", dmem_wdata,    i_b);
            check("dmem_we",    32'(dmem_we),  32'(i_wmem));
        end
    endtask

    // Applies the rising edge to the model using the inputs present at that edge.
    task automatic model_edge();
        if (phase == 1 && !dmem_ack) begin
            if (cyc_in_access == TO + 1) begin
                phase = 2;
                mmo_e = '0;
            end else begin
                cyc_in_access++;
            end
        end else begin
            if (phase == 1 && i_m2reg) mmo_e = dmem_rdata;
            pres = 1; i_wreg = ewreg; i_m2reg = em2reg; i_wmem = ewmem;
            i_rn = ern; i_alu = ealu; i_b = eb;
            if (em2reg || ewmem) begin
                if (ealu[1:0] == 2'b00) begin
                    phase = 1;
                    cyc_in_access = 1;
                    plan_k = $urandom_range(0, TO + 1);
                end else begin
                    phase = 2;
                    mmo_e = '0;
                end
            end else begin
                phase = 0;
            end
        end
    endtask

    task automatic drive(input bit w, input bit m2, input bit wm, input logic [4:0] rn,
                         input logic [31:0] alu, input logic [31:0] b,
                         input bit ack, input logic [31:0] rd);
        ewreg = w; em2reg = m2; ewmem = wm; ern = rn; ealu = alu; eb = b;
        dmem_ack = ack; dmem_rdata = rd;
        #1;
    endtask

    task automatic tick();
        compare();
        @(posedge clock);
        model_edge();
        #2;
    endtask

    task automatic bubble(input bit ack);
        drive(0, 0, 0, 5'd0, 32'd0, 32'd0, ack, 32'h0BAD_F00D);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int rq, st, vl;
        resetn = 1'b0;
        model_reset();
        bubble(0);
        #12;
        check("rst_mvalid", 32'(mvalid), 32'd0);
        check("rst_req",    32'(dmem_req), 32'd0);
        check("rst_mmo",    mmo, 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // ALU op passes through in one cycle
        drive(1, 0, 0, 5'd5, 32'h1234, 32'd0, 0, 32'd0);
        tick();
        bubble(0);
        check("alu_mwreg",  32'(mwreg), 32'd1);
        check("alu_mrn",    32'(mrn), 32'd5);
        check("alu_malu",   malu, 32'h1234);
        check("alu_mvalid", 32'(mvalid), 32'd1);
        check("alu_req",    32'(dmem_req), 32'd0);
        check("alu_stall",  32'(mem_stall), 32'd0);
        tick();

        // Misaligned load
        drive(1, 1, 0, 5'd3, 32'h102, 32'd0, 0, 32'd0);
        tick();
        bubble(0);
        check("mis_err",    32'(mem_err), 32'd1);
        check("mis_mvalid", 32'(mvalid), 32'd1);
        check("mis_mwreg",  32'(mwreg), 32'd0);
        check("mis_req",    32'(dmem_req), 32'd0);
        check("mis_stall",  32'(mem_stall), 32'd0);
        tick();
        bubble(0);
        check("mis_err_once", 32'(mem_err), 32'd0);
        tick();

        // Load acked in the third BUSY cycle
        drive(0, 1, 0, 5'd9, 32'h100, 32'd0, 0, 32'd0);
        tick();
        rq = 0; st = 0; vl = 0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 5'd0, 32'd0, 32'd0, (i == 2), 32'hDEAD_BEEF);
            rq += int'(dmem_req); st += int'(mem_stall); vl += int'(mvalid);
            tick();
        end
        check("ld_req_cycles",   32'(rq), 32'd3);
        check("ld_stall_cycles", 32'(st), 32'd2);
        check("ld_valid_cycles", 32'(vl), 32'd1);
        bubble(0);
        check("ld_mmo", mmo, 32'hDEAD_BEEF);
        tick();

        // Back-to-back stores, each acked in the first BUSY cycle
        drive(0, 0, 1, 5'd0, 32'h10, 32'hAAAA, 0, 32'd0);
        tick();
        drive(0, 0, 1, 5'd0, 32'h14, 32'hBBBB, 1, 32'd0);
        check("st0_req",   32'(dmem_req), 32'd1);
        check("st0_addr",  dmem_addr, 32'h10);
        check("st0_we",    32'(dmem_we), 32'd1);
        check("st0_stall", 32'(mem_stall), 32'd0);
        tick();
        bubble(1);
        check("st1_req",   32'(dmem_req), 32'd1);
        check("st1_addr",  dmem_addr, 32'h14);
        check("st1_wdata", dmem_wdata, 32'hBBBB);
        check("st1_stall", 32'(mem_stall), 32'd0);
        tick();
        bubble(0);
        check("st_done_req", 32'(dmem_req), 32'd0);
        tick();

        // Timeout with no ack; mmo still holds DEADBEEF going in
        drive(1, 1, 0, 5'd4, 32'h200, 32'd0, 0, 32'd0);
        tick();
        rq = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 5'd7, 32'h777, 32'd0, 0, 32'd0);
            rq += int'(dmem_req);
            tick();
        end
        check("to_req_cycles", 32'(rq), 32'd5);
        drive(1, 0, 0, 5'd7, 32'h777, 32'd0, 0, 32'd0);
        // the sixth loop iteration was the ERR cycle; the next op is now in M
        check("to_next_malu", malu, 32'h777);
        check("to_next_mrn",  32'(mrn), 32'd7);
        check("to_next_err",  32'(mem_err), 32'd0);
        check("to_mmo",       mmo, 32'd0);
        tick();

        // Timeout again, this time inspecting the ERR cycle itself
        drive(1, 1, 0, 5'd4, 32'h204, 32'd0, 0, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 5'd8, 32'h888, 32'd0, 0, 32'd0);
            tick();
        end
        drive(1, 0, 0, 5'd8, 32'h888, 32'd0, 0, 32'd0);
        check("to_err",   32'(mem_err), 32'd1);
        check("to_mwreg", 32'(mwreg), 32'd0);
        check("to_ereq",  32'(dmem_req), 32'd0);
        check("to_malu",  malu, 32'h204);
        tick();

        // Reset in the second BUSY cycle, then a late ack
        drive(1, 1, 0, 5'd2, 32'h300, 32'd0, 0, 32'd0);
        tick();
        bubble(0);
        tick();
        bubble(0);
        resetn = 1'b0;
        #1;
        check("rr_req",    32'(dmem_req), 32'd0);
        check("rr_err",    32'(mem_err), 32'd0);
        check("rr_stall",  32'(mem_stall), 32'd0);
        check("rr_mvalid", 32'(mvalid), 32'd0);
        check("rr_mwreg",  32'(mwreg), 32'd0);
        check("rr_malu",   malu, 32'd0);
        model_reset();
        drive(0, 0, 0, 5'd0, 32'd0, 32'd0, 1, 32'h5555_5555);
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        drive(0, 0, 0, 5'd0, 32'd0, 32'd0, 1, 32'h5555_5555);
        tick();
        bubble(0);
        check("late_ack_mmo", mmo, 32'd0);
        check("late_ack_req", 32'(dmem_req), 32'd0);
        tick();

        // Random instruction stream with planned ack latencies
        for (int n = 0; n < 3000; n++) begin
            int          kind;
            logic [31:0] alu;
            bit          ack;
            kind = $urandom_range(0, 7);
            alu  = $urandom & 32'hFFFF_FFFC;
            if (kind == 7) alu = alu | 32'($urandom_range(1, 3));
            if (phase == 1) ack = (cyc_in_access == plan_k);
            else            ack = ($urandom_range(0, 3) == 0);
            drive(1'($urandom_range(0, 1)),
                  (kind == 3) || (kind == 4) || (kind == 7),
                  (kind == 5) || (kind == 6),
                  5'($urandom), alu, $urandom, ack, $urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_mem_stage.md
PIPE_MEM_STAGE -- requirements
Module: pipe_mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of BUSY cycles to wait for dmem_ack before the access is aborted; legal range 1..255.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 ewreg, em2reg, ewmem  input  1 each  EXE-stage controls: register write, load, store.
REQ-005 ealu  input  32  EXE ALU result, used as the memory byte address.
REQ-006 eb  input  32  EXE store data.
REQ-007 ern  input  5  EXE destination register number.
REQ-008 mwreg, mm2reg  output  1 each  registered MEM-stage controls.
REQ-009 mrn  output  5  registered destination register.
REQ-010 malu  output  32  registered ALU result.
REQ-011 mmo  output  32  load data captured from memory.
REQ-012 mvalid  output  1  high when the M-stage instruction is complete this cycle, so WB may consume it.
REQ-013 mem_stall  output  1  high freezes the IF, ID and EXE stages and their pipeline registers.
REQ-014 mem_err  output  1  one-cycle pulse marking a misaligned or timed-out access.
REQ-015 dmem_req, dmem_we  output  1 each  data-memory request and write enable.
REQ-016 dmem_addr, dmem_wdata  output  32 each  memory address and write data.
REQ-017 dmem_ack  input  1  memory completion, a one-cycle pulse.
REQ-018 dmem_rdata  input  32  read data, valid only in a cycle where dmem_ack is high.

Function
REQ-019 The stage holds an EX/M register: mwreg, mm2reg, mwmem, mrn, malu, mb.
- This register loads the E* inputs on every rising edge where mem_stall is 0.
- It holds its value while mem_stall is 1.
REQ-020 The FSM has three states: IDLE, BUSY and ERR.
REQ-021 A memory op is a loaded instruction with mm2reg or mwmem set.
REQ-022 IDLE state:
- On the edge that loads an aligned memory op (ealu[1:0]==0), go to BUSY.
- On the edge that loads a misaligned memory op, go to ERR.
- On any other edge, stay in IDLE.
REQ-023 BUSY state:
- dmem_req = 1, dmem_addr = malu, dmem_wdata = mb, dmem_we = mwmem.
- All four signals stay stable until the exit edge.
REQ-024 mem_stall = (state==BUSY) && !dmem_ack; it is 0 in IDLE and in ERR.
REQ-025 Exit from BUSY on dmem_ack:
- At that edge, mmo captures dmem_rdata if mm2reg is 1; otherwise mmo is unchanged.
- In the same edge, the EX/M register loads the next E instruction.
- The next state follows the same rules as REQ-022.
REQ-026 Timing: if dmem_ack arrives in the k-th BUSY cycle (k>=1), the op occupies M for k cycles and mem_stall is high for k-1 cycles.
REQ-027 BUSY cycle counter:
- 8 bits wide, cleared when the FSM enters BUSY.
- Increments once per BUSY cycle without ack.
REQ-028 Timeout:
- When the counter equals TIMEOUT and dmem_ack is still 0, the access aborts and the FSM goes to ERR.
- dmem_req drops at that edge.
- The EX/M register is not reloaded at that edge; mem_stall is still 1 in that cycle.
REQ-029 ERR state (lasts exactly one cycle):
- mem_err = 1, mvalid = 1, and the mwreg output is forced to 0 so write-back is suppressed; mmo = 0.
- The EX/M register loads the next E instruction at the end of the ERR cycle.
- The next state follows the same rules as REQ-022.
REQ-030 mvalid = 1 in these cases:
- In IDLE when a loaded instruction is present; this includes non-memory ops and bubbles with all controls 0.
- In BUSY in the cycle where dmem_ack is high.
- In ERR.
In every other cycle, mvalid = 0.
REQ-031 dmem_ack is ignored outside BUSY; it has no effect on state, mmo or any output.
REQ-032 Non-memory ops never assert dmem_req; they pass through M in one cycle.
REQ-033 Any output not driven by an active rule holds its last value; there are no combinational paths from the E* inputs to any output.

Reset
REQ-034 While resetn is 0: the FSM is in IDLE; every output and internal register is 0, including the counter and mmo.
REQ-035 Reset asserted mid-access drops dmem_req immediately and asynchronously; the aborted access gives no mem_err pulse.
REQ-036 The first rising edge after resetn rises behaves as IDLE with the EX/M register empty.

Verification
REQ-037 ALU op ewreg=1, ern=5, ealu=0x1234 -> next cycle: mwreg=1, mrn=5, malu=0x1234, mvalid=1, dmem_req=0, mem_stall=0.
REQ-038 Load at ealu=0x100, with ack in the 3rd BUSY cycle and rdata=0xDEADBEEF:
- dmem_req is high for 3 cycles; mem_stall is high for 2 cycles.
- mmo becomes 0xDEADBEEF; mvalid is high in the ack cycle only.
REQ-039 Back-to-back stores to 0x10 then 0x14, each acked in its first BUSY cycle -> two consecutive dmem_req cycles, dmem_we=1, addresses 0x10 then 0x14, mem_stall never high.
REQ-040 Load at ealu=0x102 -> no dmem_req; one cycle with mem_err=1, mvalid=1, mwreg=0; no stall.
REQ-041 TIMEOUT=4, no ack:
- dmem_req is high for 5 cycles, then drops.
- Next cycle: mem_err=1, mwreg=0, mmo=0.
- The next instruction then enters M.
REQ-042 resetn pulled low during the 2nd BUSY cycle:
- dmem_req=0 and all outputs 0 immediately, with no mem_err.
- A late dmem_ack after reset is ignored.
